bayer_pattern_gen: RTL and testbench

BAYER_PATTERN_GEN -- requirements
Module: bayer_pattern_gen

---
 rtl/bayer_pattern_gen.sv | 129 ++++++++++++
 tb/tb_bayer_pattern_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bayer_pattern_gen.sv
// bayer_pattern_gen: raw 12-bit test-pattern source with line/frame timing.
// Ports:
//   iCLK, iRST       clock (rising edge), asynchronous active-high reset
//   iSTART           frame request, honoured only while idle
//   iCONT            chain the next frame directly after vertical blanking
//   iMODE, iLEVEL    pattern select and level, captured at each frame start
//   oDATA, oDVAL     pixel value and valid
//   oX_Cont, oY_Cont current column and line
//   oBUSY            high whenever a frame is in progress
//   oFRAME_DONE      one-cycle pulse on the last vertical-blank cycle
module bayer_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic        iCONT,
    input  logic [1:0]  iMODE,
    input  logic [11:0] iLEVEL,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic        oBUSY,
    output logic        oFRAME_DONE
);
    localparam int BMAX = H_BLANK > V_BLANK ? H_BLANK : V_BLANK;
    localparam int BW = $clog2(BMAX + 1);
    localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0] X_HALF = 11'(H_ACTIVE / 2);
    localparam logic [BW-1:0] HB_LAST = BW'(H_BLANK - 1);
    localparam logic [BW-1:0] VB_LAST = BW'(V_BLANK - 1);
    localparam logic [BW-1:0] ONE = BW'(1);

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    state_t          state;
    logic [1:0]      mode;
    logic [11:0]     level;
    logic [BW-1:0]   cnt;
    logic            frame_start;

    function automatic logic [11:0] pix(input logic [1:0] m, input logic [11:0] l,
                                        input logic [10:0] px, input logic [10:0] py);
        return m == 2'd0 ? l :
               m == 2'd1 ? {px[9:0], 2'b00} :
               m == 2'd2 ? {12{px[3] ^ py[3]}} :
               (px >= X_HALF ? l : 12'h000);
    endfunction

    assign frame_start = (state == IDLE && iSTART) || (state == VBLANK && cnt == VB_LAST && iCONT);

    // Pixel outputs are computed from the next column/line so they land in the
    // same register stage as oX_Cont/oY_Cont.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state       <= IDLE;
            mode        <= 2'd0;
            level       <= 12'h000;
            cnt         <= '0;
            oDATA       <= 12'h000;
            oDVAL       <= 1'b0;
            oX_Cont     <= 11'd0;
            oY_Cont     <= 11'd0;
            oBUSY       <= 1'b0;
            oFRAME_DONE <= 1'b0;
        end else begin
            oFRAME_DONE <= 1'b0;
            if (frame_start) begin
                state   <= ACTIVE;
                mode    <= iMODE;
                level   <= iLEVEL;
                cnt     <= '0;
                oX_Cont <= 11'd0;
                oY_Cont <= 11'd0;
                oDVAL   <= 1'b1;
                oDATA   <= pix(iMODE, iLEVEL, 11'd0, 11'd0);
                oBUSY   <= 1'b1;
            end else begin
                case (state)
                    ACTIVE: begin
                        if (oX_Cont == X_LAST) begin
                            state   <= HBLANK;
                            cnt     <= '0;
                            oX_Cont <= 11'd0;
                            oDVAL   <= 1'b0;
                            oDATA   <= 12'h000;
                        end else begin
                            oX_Cont <= oX_Cont + 11'd1;
                            oDATA   <= pix(mode, level, oX_Cont + 11'd1, oY_Cont);
                        end
                    end
                    HBLANK: begin
                        if (cnt == HB_LAST) begin
                            cnt <= '0;
                            if (oY_Cont < Y_LAST) begin
                                state   <= ACTIVE;
                                oY_Cont <= oY_Cont + 11'd1;
                                oDVAL   <= 1'b1;
                                oDATA   <= pix(mode, level, 11'd0, oY_Cont + 11'd1);
                            end else begin
                                state       <= VBLANK;
                                oY_Cont     <= 11'd0;
                                oFRAME_DONE <= (V_BLANK == 1);
                            end
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    VBLANK: begin
                        if (cnt == VB_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                            oBUSY <= 1'b0;
                        end else begin
                            cnt         <= cnt + ONE;
                            oFRAME_DONE <= (cnt + ONE) == VB_LAST;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bayer_pattern_gen.sv
// tb_bayer_pattern_gen: scoreboard bench for bayer_pattern_gen (4x2 and 16x16 instances).
module tb_bayer_pattern_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_start, a_cont, b_start, b_cont;
    logic [1:0]  a_mode, b_mode;
    logic [11:0] a_level, b_level, a_data, b_data;
    logic        a_dval, b_dval, a_busy, b_busy, a_done, b_done;
    logic [10:0] a_x, a_y, b_x, b_y;
    int          checks = 0;
    int          failures = 0;
    logic [33:0] qa[$];
    logic [33:0] qb[$];
    int          n, d;
    bit          ok;

    always #5 clk = ~clk;

    bayer_pattern_gen #(.H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(2), .V_BLANK(3)) dut_a (
        .iCLK(clk), .iRST(rst), .iSTART(a_start), .iCONT(a_cont), .iMODE(a_mode),
        .iLEVEL(a_level), .oDATA(a_data), .oDVAL(a_dval), .oX_Cont(a_x), .oY_Cont(a_y),
        .oBUSY(a_busy), .oFRAME_DONE(a_done));

    bayer_pattern_gen #(.H_ACTIVE(16), .V_ACTIVE(16), .H_BLANK(2), .V_BLANK(3)) dut_b (
        .iCLK(clk), .iRST(rst), .iSTART(b_start), .iCONT(b_cont), .iMODE(b_mode),
        .iLEVEL(b_level), .oDATA(b_data), .oDVAL(b_dval), .oX_Cont(b_x), .oY_Cont(b_y),
        .oBUSY(b_busy), .oFRAME_DONE(b_done));

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (a_dval) begin
                if (qa.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL a_unexpected_pixel actual=%h required=none", {a_data, a_x, a_y});
                end else chk("a_pixel", {a_data, a_x, a_y}, qa.pop_front());
            end else chk("a_blank_data", a_data, 40'd0);
            if (b_dval) begin
                if (qb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected_pixel actual=%h required=none", {b_data, b_x, b_y});
                end else chk("b_pixel", {b_data, b_x, b_y}, qb.pop_front());
            end else chk("b_blank_data", b_data, 40'd0);
        end
    end

    task automatic push_a(input logic [11:0] d0, input logic [11:0] d1,
                          input logic [11:0] d2, input logic [11:0] d3);
        logic [11:0] v[4];
        v = '{d0, d1, d2, d3};
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                qa.push_back({v[x], 11'(x), 11'(y)});
    endtask

    task automatic start_a();
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
    endtask

    task automatic wait_idle_a(output int cnt, output int done_at);
        cnt = 0;
        done_at = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!a_busy) return;
            cnt++;
            if (a_done) done_at = cnt;
        end
    endtask

    task automatic wait_done_a(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_done) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        {a_start, a_cont, a_mode, a_level} = '0;
        {b_start, b_cont, b_mode, b_level} = '0;
        #12;
        chk("a_reset_state", {a_data, a_dval, a_x, a_y, a_busy, a_done}, 40'd0);
        chk("b_reset_state", {b_data, b_dval, b_x, b_y, b_busy, b_done}, 40'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("a_idle_after_reset", {a_busy, a_dval}, 40'd0);

        // single ramp frame
        a_mode = 2'd1; a_cont = 1'b0;
        push_a(12'd0, 12'd4, 12'd8, 12'd12);
        start_a();
        wait_idle_a(n, d);
        chk("ramp_busy_len", n, 40'd15);
        chk("ramp_done_at", d, 40'd15);

        // continuous flat frames
        a_mode = 2'd0; a_level = 12'h5A5; a_cont = 1'b1;
        push_a(12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5);
        push_a(12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5);
        start_a();
        wait_done_a(ok);
        chk("cont_done_seen", ok, 40'd1);
        @(negedge clk);
        chk("cont_restart", {a_dval, a_x, a_y}, {1'b1, 22'd0});
        a_cont = 1'b0;
        wait_idle_a(n, d);
        chk("cont_f2_busy_len", n, 40'd14);
        chk("cont_f2_done_at", d, 40'd14);

        // step pattern with a mid-frame level change
        a_mode = 2'd3; a_level = 12'h800; a_cont = 1'b1;
        push_a(12'h000, 12'h000, 12'h800, 12'h800);
        push_a(12'h000, 12'h000, 12'h100, 12'h100);
        start_a();
        repeat (2) @(posedge clk);
        #1 a_level = 12'h100;
        wait_done_a(ok);
        chk("step_done_seen", ok, 40'd1);
        @(negedge clk);
        a_cont = 1'b0;
        wait_idle_a(n, d);
        chk("step_f2_busy_len", n, 40'd14);

        // start pulse during HBLANK is ignored
        a_mode = 2'd1;
        push_a(12'd0, 12'd4, 12'd8, 12'd12);
        start_a();
        repeat (4) @(posedge clk);
        #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        wait_idle_a(n, d);
        chk("busy_start_rest_len", n, 40'd10);
        repeat (10) @(negedge clk);
        chk("busy_start_no_second", {a_busy, 6'(qa.size())}, 40'd0);

        // asynchronous reset while column 2 is on the outputs
        qa.push_back({12'd0, 11'd0, 11'd0});
        qa.push_back({12'd4, 11'd1, 11'd0});
        start_a();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", {a_data, a_dval, a_x, a_y, a_busy, a_done}, 40'd0);
        chk("async_reset_queue", qa.size(), 40'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("after_reset_idle", {a_busy, a_dval}, 40'd0);

        // 16x16 checker
        b_mode = 2'd2;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                qb.push_back({((x / 8 + y / 8) % 2 == 1) ? 12'hFFF : 12'h000, 11'(x), 11'(y)});
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!b_busy) break;
            n++;
        end
        chk("checker_busy_len", n, 40'd291);

        chk("a_queue_empty", qa.size(), 40'd0);
        chk("b_queue_empty", qb.size(), 40'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
